ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester arbiter that shares the `ram` block's single read port and single byte-enabled write port between requester 0 (CPU data side) and requester 1 (debug/DMA side). The read and write channels are arbitrated independently, each with round-robin fairness, an optional lock for back-to-back bursts, and a starvation bound. The block also returns read data to the correct requester, accounting for the RAM's one-cycle read latency. It sits between the requesters and `ram`, and it is the only driver of `ram`'s `dread_addr`, `dwrite_addr`, `dwrite_data` and `dwrite_en`.

## Interface
- `HOLD_LIMIT`, default 4: maximum number of consecutive grants that one requester may take on a channel, via lock, while the other requester is waiting. Legal range 1..15.
- `clk` in 1: single clock for the block.
- `reset` in 1: synchronous, active-high reset.
- `rdN_req` in 1 (N=0,1): read request.
- `rdN_addr` in 16: byte address of the read.
- `rdN_lock` in 1: keep the read grant on the next cycle if `rdN_req` is still high.
- `rdN_ack` out 1: read address accepted this cycle (combinational).
- `rdN_valid` out 1: `rdN_data` is valid this cycle; asserted one cycle after `rdN_ack`.
- `rdN_data` out 16: read data; `dread_data` routed to both requesters.
- `wrN_req` in 1: write request.
- `wrN_addr` in 16: byte address of the write.
- `wrN_data` in 16: write data.
- `wrN_en` in 2: byte enables, with the same meaning as `ram`'s `dwrite_en`.
- `wrN_lock` in 1: keep the write grant on the next cycle.
- `wrN_ack` out 1: write performed this cycle (combinational).
- `ram_dread_addr` out 16: to `ram` `dread_addr`.
- `ram_dread_data` in 16: from `ram` `dread_data`.
- `ram_dwrite_addr` out 16: to `ram` `dwrite_addr`.
- `ram_dwrite_data` out 16: to `ram` `dwrite_data`.
- `ram_dwrite_en` out 2: to `ram` `dwrite_en`.

## Operation
- There are two identical channel arbiters, one for reads and one for writes. Each holds the following state:
  - `prio`: the preferred port.
  - `owner`: the port holding a lock, if any.
  - `locked` flag.
  - `hold_cnt`: 4-bit count of consecutive grants to `owner`.
- Each channel runs this state machine:
  - **IDLE**: no lock is held. Grant goes to the only requester if just one is requesting. If both request, grant goes to `prio`. After a grant, `prio` becomes the other port. If the granted port's lock input is high, the channel moves to **LOCKED**: `owner` = granted port, `hold_cnt` = 1.
  - **LOCKED**: if `owner` is still requesting and has its lock high, grant goes to `owner`, and `hold_cnt` increments while the other port is requesting. When `hold_cnt` == `HOLD_LIMIT` and the other port is requesting, `owner` is refused and the other port is granted. In that case, or whenever `owner` drops its request or lock, the channel returns to **IDLE** arbitration in the same cycle with `prio` = the non-owner.
- `hold_cnt` does not increment while the other port is idle, so an uncontended lock is unbounded.
- The granted port's address, data and enables are muxed onto the `ram_*` outputs. With no write grant, `ram_dwrite_en` = 2'b00 and the write address and data are don't-care. With no read grant, `ram_dread_addr` holds its previous value.
- A write with `wrN_en` = 2'b00 is still acked and still consumes a grant.
- Read return logic:
  - A registered `rsel` (port) and `rpend` are set in the cycle of a read grant.
  - On the next cycle, `rdN_valid` = `rpend && rsel==N`.
  - Both `rdN_data` outputs = `ram_dread_data`, unregistered.
- Unaligned 16-bit accesses are passed through unchanged; `ram` handles the even/odd split.
- Same-cycle read and write from different ports to the same word: the read returns the new data, because of `ram`'s write bypass. The arbiter adds no ordering logic beyond this.

## Timing
- Acks are combinational from the current requests and state; there is no added latency on the address or command path.
- Read data latency is 1 cycle after `rdN_ack`. Back-to-back reads give one result per cycle, with the data alternating between ports exactly as the grants alternated.
- Reset values (taken on the first `clk` edge with `reset` high):
  - `prio` = 0, `locked` = 0, `hold_cnt` = 0, `rpend` = 0.
  - All acks and `rdN_valid` = 0.
  - `ram_dwrite_en` = 2'b00.
  - `ram_dread_addr` = 16'h0000.
- While `reset` is high, no grants are issued. A read granted in the cycle before `reset` rises produces no `rdN_valid`.
- `hold_cnt` saturates at `HOLD_LIMIT` and does not wrap. `prio` toggles only on a contested grant from IDLE or on a forced hand-over.

## Test plan
- **Reset:** hold `reset` high for 3 cycles with all requests high -> every ack = 0, `ram_dwrite_en` = 00. In the first cycle after reset, with both reads requesting, `rd0_ack` = 1.
- **Contested reads, no locks:** both ports request continuously, `rd0_addr` = 16'h3C00, `rd1_addr` = 16'h3C02 -> acks alternate 0,1,0,1. `rdN_valid` follows each ack by one cycle, carrying the RAM contents at the matching address.
- **Lock with starvation bound:** `HOLD_LIMIT` = 4, `wr0_lock` = 1, both write requests held -> `wr0` is acked 4 cycles in a row, then `wr1` on the 5th, then `wr0` again.
- **Uncontended lock:** `rd1_lock` = 1 with `rd0_req` = 0 for 20 cycles -> 20 consecutive `rd1_ack`. Raising `rd0_req` then bounds `rd1` to 4 more grants.
- **Write/read same word:** `wr1` writes 16'hBEEF, en = 11, at 16'h3C10 while `rd0` reads 16'h3C10 in the same cycle -> `rd0_valid` next cycle with `rd0_data` = 16'hBEEF.
- **Reset mid-read:** `rd0_ack` in cycle t, `reset` high in cycle t+1 -> `rd0_valid` = 0 in t+1. No stale valid after reset is released.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_port_arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface ram_port_arbiter_if;
  logic        rd0_req, rd1_req;
  logic [15:0] rd0_addr, rd1_addr;
  logic        rd0_lock, rd1_lock;
  logic        rd0_ack, rd1_ack;
  logic        rd0_valid, rd1_valid;
  logic [15:0] rd0_data, rd1_data;

  logic        wr0_req, wr1_req;
  logic [15:0] wr0_addr, wr1_addr;
  logic [15:0] wr0_data, wr1_data;
  logic [1:0]  wr0_en, wr1_en;
  logic        wr0_lock, wr1_lock;
  logic        wr0_ack, wr1_ack;

  logic [15:0] ram_dread_addr;
  logic [15:0] ram_dread_data;
  logic [15:0] ram_dwrite_addr;
  logic [15:0] ram_dwrite_data;
  logic [1:0]  ram_dwrite_en;

  modport slave (
    input  rd0_req, rd1_req, rd0_addr, rd1_addr, rd0_lock, rd1_lock,
    output rd0_ack, rd1_ack, rd0_valid, rd1_valid, rd0_data, rd1_data,
    input  wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data,
    input  wr0_en, wr1_en, wr0_lock, wr1_lock,
    output wr0_ack, wr1_ack,
    output ram_dread_addr, ram_dwrite_addr, ram_dwrite_data, ram_dwrite_en,
    input  ram_dread_data
  );

  modport master (
    output rd0_req, rd1_req, rd0_addr, rd1_addr, rd0_lock, rd1_lock,
    input  rd0_ack, rd1_ack, rd0_valid, rd1_valid, rd0_data, rd1_data,
    output wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data,
    output wr0_en, wr1_en, wr0_lock, wr1_lock,
    input  wr0_ack, wr1_ack,
    input  ram_dread_addr, ram_dwrite_addr, ram_dwrite_data, ram_dwrite_en,
    output ram_dread_data
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the RAM read port and write port between two requesters using
// independent round-robin channels with bounded lock bursts.
module ram_port_arbiter_chan #(
  parameter int HOLD_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  output logic [1:0] o_gnt,
  output logic       o_sel
);
  typedef enum logic {S_IDLE, S_LOCKED} state_t;
  localparam logic [3:0] HL = 4'(HOLD_LIMIT);

  state_t     r_state, w_state_nxt;
  logic       r_prio, w_prio_nxt;
  logic       r_owner, w_owner_nxt;
  logic [3:0] r_hold, w_hold_nxt;
  logic       w_any, w_sel, w_arb, w_p, w_other;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // hold counts grants made while the other port waits, so the burst
  // seen by a waiting port is capped at HOLD_LIMIT whatever the entry.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    w_any       = 1'b0;
    w_sel       = 1'b0;
    w_arb       = 1'b1;
    w_p         = r_prio;
    w_other     = ~r_owner;
    if (r_state == S_LOCKED) begin
      w_p = w_other;
      if (i_req[r_owner] && i_lock[r_owner] &&
          !(r_hold == HL && i_req[w_other])) begin
        w_arb = 1'b0;
        w_any = 1'b1;
        w_sel = r_owner;
        if (i_req[w_other] && r_hold < HL)
          w_hold_nxt = r_hold + 4'd1;
      end
    end
    if (w_arb) begin
      w_state_nxt = S_IDLE;
      w_hold_nxt  = '0;
      w_prio_nxt  = w_p;
      if (i_req[0] && i_req[1]) begin
        w_any      = 1'b1;
        w_sel      = w_p;
        w_prio_nxt = ~w_p;
      end else if (i_req[0]) begin
        w_any = 1'b1;
        w_sel = 1'b0;
      end else if (i_req[1]) begin
        w_any = 1'b1;
        w_sel = 1'b1;
      end
      if (w_any && i_lock[w_sel]) begin
        w_state_nxt = S_LOCKED;
        w_owner_nxt = w_sel;
        w_hold_nxt  = i_req[~w_sel] ? 4'd1 : 4'd0;
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (w_any && !reset)
      o_gnt[w_sel] = 1'b1;
    o_sel = w_sel;
  end
endmodule

module ram_port_arbiter #(
  parameter int HOLD_LIMIT = 4
) (
  input logic                 clk,
  input logic                 reset,
  ram_port_arbiter_if.slave   bus
);
  logic [1:0]  w_rd_gnt, w_wr_gnt;
  logic        w_rd_sel, w_wr_sel, w_rd_any;
  logic [15:0] w_rd_addr;
  logic [15:0] r_rd_addr;
  logic        r_rpend, r_rsel;

  ram_port_arbiter_chan #(.HOLD_LIMIT(HOLD_LIMIT)) u_rd (
    .clk(clk), .reset(reset),
    .i_req({bus.rd1_req, bus.rd0_req}), .i_lock({bus.rd1_lock, bus.rd0_lock}),
    .o_gnt(w_rd_gnt), .o_sel(w_rd_sel)
  );

  ram_port_arbiter_chan #(.HOLD_LIMIT(HOLD_LIMIT)) u_wr (
    .clk(clk), .reset(reset),
    .i_req({bus.wr1_req, bus.wr0_req}), .i_lock({bus.wr1_lock, bus.wr0_lock}),
    .o_gnt(w_wr_gnt), .o_sel(w_wr_sel)
  );

  assign w_rd_any  = |w_rd_gnt;
  assign w_rd_addr = w_rd_any ? (w_rd_sel ? bus.rd1_addr : bus.rd0_addr) : r_rd_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_rpend   <= 1'b0;
      r_rsel    <= 1'b0;
    end else begin
      r_rpend <= w_rd_any;
      r_rsel  <= w_rd_sel;
      if (w_rd_any)
        r_rd_addr <= w_rd_addr;
    end
  end

  assign bus.rd0_ack        = w_rd_gnt[0];
  assign bus.rd1_ack        = w_rd_gnt[1];
  // Reset masks a return that was launched just before it rose.
  assign bus.rd0_valid      = r_rpend && !r_rsel && !reset;
  assign bus.rd1_valid      = r_rpend &&  r_rsel && !reset;
  assign bus.rd0_data       = bus.ram_dread_data;
  assign bus.rd1_data       = bus.ram_dread_data;
  assign bus.ram_dread_addr = w_rd_addr;

  assign bus.wr0_ack         = w_wr_gnt[0];
  assign bus.wr1_ack         = w_wr_gnt[1];
  assign bus.ram_dwrite_addr = w_wr_sel ? bus.wr1_addr : bus.wr0_addr;
  assign bus.ram_dwrite_data = w_wr_sel ? bus.wr1_data : bus.wr0_data;
  assign bus.ram_dwrite_en   = w_wr_gnt[1] ? bus.wr1_en :
                               w_wr_gnt[0] ? bus.wr0_en : 2'b00;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a byte-enabled RAM model
// (one-cycle read latency, same-cycle write bypass).
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_port_arbiter_if bus();
  ram_port_arbiter #(.HOLD_LIMIT(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] mem [0:255];

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] d,
                                        input logic [1:0] en);
    return {en[1] ? d[15:8] : old_w[15:8], en[0] ? d[7:0] : old_w[7:0]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
      bus.ram_dread_data <= mem[bus.ram_dread_addr[8:1]];
    end else begin
      if (bus.ram_dwrite_en != 2'b00)
        mem[bus.ram_dwrite_addr[8:1]] <= merge(mem[bus.ram_dwrite_addr[8:1]],
                                               bus.ram_dwrite_data, bus.ram_dwrite_en);
      if (bus.ram_dwrite_en != 2'b00 && bus.ram_dwrite_addr[8:1] == bus.ram_dread_addr[8:1])
        bus.ram_dread_data <= merge(mem[bus.ram_dwrite_addr[8:1]],
                                    bus.ram_dwrite_data, bus.ram_dwrite_en);
      else
        bus.ram_dread_data <= mem[bus.ram_dread_addr[8:1]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic all_idle();
    bus.rd0_req = 0; bus.rd1_req = 0; bus.rd0_lock = 0; bus.rd1_lock = 0;
    bus.wr0_req = 0; bus.wr1_req = 0; bus.wr0_lock = 0; bus.wr1_lock = 0;
  endtask

  logic [1:0]  exp_rd_ack [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
  logic [1:0]  exp_rd_vld [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [15:0] exp_rd_dat [5] = '{16'h0000, 16'h1000, 16'h1001, 16'h1000, 16'h1001};
  logic [1:0]  exp_wr_ack [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
  logic [1:0]  exp_lk_ack [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

  initial begin
    reset = 1;
    all_idle();
    bus.rd0_addr = '0; bus.rd1_addr = '0;
    bus.wr0_addr = '0; bus.wr1_addr = '0; bus.wr0_data = '0; bus.wr1_data = '0;
    bus.wr0_en = 2'b11; bus.wr1_en = 2'b11;
    @(negedge clk);

    // Reset with everything requesting
    bus.rd0_req = 1; bus.rd1_req = 1; bus.wr0_req = 1; bus.wr1_req = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rst_acks", {bus.rd1_ack, bus.rd0_ack, bus.wr1_ack, bus.wr0_ack}, 0);
      check("rst_wen", bus.ram_dwrite_en, 0);
      check("rst_valid", {bus.rd1_valid, bus.rd0_valid}, 0);
      check("rst_raddr", bus.ram_dread_addr, 0);
      @(negedge clk);
    end

    // Contested reads, no locks
    reset = 0;
    bus.wr0_req = 0; bus.wr1_req = 0;
    bus.rd0_addr = 16'h3C00; bus.rd1_addr = 16'h3C02;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin bus.rd0_req = 0; bus.rd1_req = 0; end
      #1;
      check("rr_ack", {bus.rd1_ack, bus.rd0_ack}, exp_rd_ack[k]);
      check("rr_valid", {bus.rd1_valid, bus.rd0_valid}, exp_rd_vld[k]);
      if (k >= 1)
        check("rr_data", exp_rd_vld[k][0] ? bus.rd0_data : bus.rd1_data, exp_rd_dat[k]);
      if (k == 0) check("rr_raddr0", bus.ram_dread_addr, 16'h3C00);
      if (k == 4) check("rr_raddr_hold", bus.ram_dread_addr, 16'h3C02);
      @(negedge clk);
    end

    // Write lock with starvation bound
    bus.wr0_req = 1; bus.wr0_lock = 1; bus.wr0_addr = 16'h3C20; bus.wr0_data = 16'h1111; bus.wr0_en = 2'b11;
    bus.wr1_req = 1; bus.wr1_lock = 0; bus.wr1_addr = 16'h3C22; bus.wr1_data = 16'h2222; bus.wr1_en = 2'b01;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("wlk_ack", {bus.wr1_ack, bus.wr0_ack}, exp_wr_ack[k]);
      if (k == 0) check("wlk_en0", bus.ram_dwrite_en, 2'b11);
      if (k == 4) begin
        check("wlk_addr1", bus.ram_dwrite_addr, 16'h3C22);
        check("wlk_data1", bus.ram_dwrite_data, 16'h2222);
        check("wlk_en1", bus.ram_dwrite_en, 2'b01);
      end
      @(negedge clk);
    end
    all_idle();
    #1;
    check("w_idle_en", bus.ram_dwrite_en, 2'b00);
    @(negedge clk);

    // Zero-enable write still acked
    bus.wr0_req = 1; bus.wr0_en = 2'b00;
    #1;
    check("wen0_ack", {bus.wr1_ack, bus.wr0_ack}, 2'b01);
    check("wen0_en", bus.ram_dwrite_en, 2'b00);
    @(negedge clk);
    all_idle();

    // Uncontended read lock, then contended
    bus.rd1_req = 1; bus.rd1_lock = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      check("ulk_ack", {bus.rd1_ack, bus.rd0_ack}, 2'b10);
      if (k >= 1) check("ulk_data", {bus.rd1_valid, bus.rd1_data}, {1'b1, 16'h1001});
      @(negedge clk);
    end
    bus.rd0_req = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("clk_ack", {bus.rd1_ack, bus.rd0_ack}, exp_lk_ack[k]);
      @(negedge clk);
    end
    all_idle();
    @(negedge clk);

    // Same-word write/read bypass
    bus.wr1_req = 1; bus.wr1_addr = 16'h3C10; bus.wr1_data = 16'hBEEF; bus.wr1_en = 2'b11;
    bus.rd0_req = 1; bus.rd0_addr = 16'h3C10;
    #1;
    check("byp_acks", {bus.rd0_ack, bus.wr1_ack}, 2'b11);
    @(negedge clk);
    all_idle();
    bus.rd1_req = 1; bus.rd1_addr = 16'h3C22;
    #1;
    check("byp_data", {bus.rd0_valid, bus.rd0_data}, {1'b1, 16'hBEEF});
    @(negedge clk);
    all_idle();
    #1;
    check("bytemask_data", {bus.rd1_valid, bus.rd1_data}, {1'b1, 16'h1022});
    @(negedge clk);

    // Reset mid-read
    bus.rd0_req = 1; bus.rd0_addr = 16'h3C00;
    #1;
    check("mrst_ack", bus.rd0_ack, 1'b1);
    @(negedge clk);
    all_idle();
    reset = 1;
    #1;
    check("mrst_valid", {bus.rd1_valid, bus.rd0_valid}, 2'b00);
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("mrst_stale", {bus.rd1_valid, bus.rd0_valid}, 2'b00);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
